// File: rtl/mark_sched_pkg.sv
// Shared types and constants for the mark-search tick scheduler.
// The stall watchdog is enabled with MARK_TICK_STALL_WATCHDOG_EN.
package mark_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int DEFAULT_STALL_TICKS = 16;

  // Width of an engine index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mark_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping from the top index back to 0.
module mark_rr_arbiter
  import mark_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic             hi_hit;
  logic             lo_hit;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Requests above the pointer beat the wrapped-around ones at or below it.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j[IDX_W-1:0]]) begin
        if (j > int'(ptr)) begin
          if (!hi_hit) begin
            hi_hit = 1'b1;
            hi_idx = j[IDX_W-1:0];
          end
        end else if (!lo_hit) begin
          lo_hit = 1'b1;
          lo_idx = j[IDX_W-1:0];
        end
      end
    end
    any    = hi_hit | lo_hit;
    idx    = hi_hit ? hi_idx : lo_idx;
    onehot = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mark_tick_scheduler.sv
// Tick-slot scheduler issuing budgeted round-robin grant strobes to the
// mark-search engines. Optional stall watchdog: MARK_TICK_STALL_WATCHDOG_EN.
module mark_tick_scheduler
  import mark_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DIV_W    = 8,
  parameter int BUDGET_W = 32
`ifdef MARK_TICK_STALL_WATCHDOG_EN
  ,
  parameter int STALL_TICKS = DEFAULT_STALL_TICKS
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DIV_W-1:0]           div,
  input  logic [BUDGET_W-1:0]        budget,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [idx_w(NUM_REQ)-1:0]  grant_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [BUDGET_W-1:0]        grants_issued
`ifdef MARK_TICK_STALL_WATCHDOG_EN
  ,
  output logic                       stalled
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  sched_state_t         state_q;
  sched_state_t         state_d;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     cnt_q;
  logic [BUDGET_W-1:0]  remaining_q;
  logic [IDX_W-1:0]     ptr_q;

  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  logic                 start_ok;
  logic                 tick;
  logic                 do_grant;
  logic                 last_grant;
  logic                 stall_hit;

  mark_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

`ifdef MARK_TICK_STALL_WATCHDOG_EN
  localparam int STALL_W = $clog2(STALL_TICKS + 1);
  logic [STALL_W-1:0] empty_ticks_q;

  assign stall_hit = tick && !arb_any && (empty_ticks_q == STALL_W'(STALL_TICKS - 1));
`else
  assign stall_hit = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort outranks a same-cycle tick, so a tick only counts when abort is low.
  always_comb begin
    start_ok   = start && (state_q != RUN);
    tick       = (state_q == RUN) && !abort && (cnt_q == '0);
    do_grant   = tick && arb_any;
    last_grant = do_grant && (remaining_q == BUDGET_W'(1));
    state_d    = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (budget == '0) ? DONE : RUN;
      RUN:        if (abort || last_grant || stall_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath; the pointer resets to the top index so index 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      cnt_q         <= '0;
      remaining_q   <= '0;
      ptr_q         <= IDX_W'(NUM_REQ - 1);
      grant         <= '0;
      grant_idx     <= '0;
      aborted       <= 1'b0;
      grants_issued <= '0;
    end else begin
      grant <= '0;
      if (start_ok) begin
        div_q         <= div;
        cnt_q         <= div;
        remaining_q   <= budget;
        grants_issued <= '0;
        aborted       <= 1'b0;
      end else if (state_q == RUN) begin
        if (abort || stall_hit) begin
          aborted <= 1'b1;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - DIV_W'(1);
        end else begin
          cnt_q <= div_q;
          if (do_grant) begin
            grant       <= arb_onehot;
            grant_idx   <= arb_idx;
            ptr_q       <= arb_idx;
            remaining_q <= remaining_q - BUDGET_W'(1);
            if (grants_issued != '1) grants_issued <= grants_issued + BUDGET_W'(1);
          end
        end
      end
    end
  end

`ifdef MARK_TICK_STALL_WATCHDOG_EN
  // Counts consecutive empty ticks; any grant or a new run clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      empty_ticks_q <= '0;
      stalled       <= 1'b0;
    end else if (start_ok) begin
      empty_ticks_q <= '0;
      stalled       <= 1'b0;
    end else if (stall_hit) begin
      empty_ticks_q <= '0;
      stalled       <= 1'b1;
    end else if (do_grant) begin
      empty_ticks_q <= '0;
    end else if (tick) begin
      empty_ticks_q <= empty_ticks_q + STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mark_tick_scheduler.sv
// Scoreboard bench for mark_tick_scheduler: expected grants are queued with
// their cycle when a run starts and matched as the strobes appear.
module tb_mark_tick_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int DIV_W    = 8;
  localparam int BUDGET_W = 32;
  localparam int IDX_W    = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [DIV_W-1:0]    div = '0;
  logic [BUDGET_W-1:0] budget = '0;
  logic [NUM_REQ-1:0]  req = '0;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [BUDGET_W-1:0] grants_issued;
`ifdef MARK_TICK_STALL_WATCHDOG_EN
  logic                stalled;
`endif

  typedef struct {
    logic [NUM_REQ-1:0] g;
    logic [IDX_W-1:0]   idx;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = NUM_REQ - 1;

  mark_tick_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .DIV_W    (DIV_W),
    .BUDGET_W (BUDGET_W)
`ifdef MARK_TICK_STALL_WATCHDOG_EN
    ,
    .STALL_TICKS (4)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .div           (div),
    .budget        (budget),
    .req           (req),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .grants_issued (grants_issued)
`ifdef MARK_TICK_STALL_WATCHDOG_EN
    ,
    .stalled       (stalled)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference round robin: first requester after p, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int p);
    int c;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (p + i) % NUM_REQ;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  // Every grant strobe seen must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset && grant !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_grant: got %b at cycle %0d, required none", grant, cyc);
      end else begin
        e = sb.pop_front();
        if (grant !== e.g || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL grant_seq: got %b at cycle %0d, required %b at cycle %0d",
                   grant, cyc, e.g, e.cyc);
        end
        checks++;
        if (grant_idx !== e.idx) begin
          errors++;
          $display("[TB] FAIL grant_idx: got %0d, required %0d", grant_idx, e.idx);
        end
      end
    end
  end

  task automatic wait_done(input int max_cycles, input string name);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while (cyc != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL cycle_wait: at cycle %0d, required %0d", cyc, target);
    end
  endtask

  // Drives a start pulse at a negedge; returns the cycle of the accepting edge.
  task automatic pulse_start(input int d, input int b, input logic [NUM_REQ-1:0] r,
                             output int s);
    @(negedge clk);
    s      = cyc + 1;
    div    = DIV_W'(d);
    budget = BUDGET_W'(b);
    req    = r;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic push_grants(input int s, input int d, input int first_tick, input int n,
                             input logic [NUM_REQ-1:0] r);
    exp_t e;
    int   w;
    for (int k = 0; k < n; k++) begin
      w     = model_pick(r, model_ptr);
      e.g   = NUM_REQ'(1) << w;
      e.idx = IDX_W'(w);
      e.cyc = s + (first_tick + k) * (d + 1);
      sb.push_back(e);
      model_ptr = w;
    end
  endtask

  task automatic check_end(input string name, input logic exp_aborted, input int exp_issued);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_state: done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    checks++;
    if (aborted !== exp_aborted) begin
      errors++;
      $display("[TB] FAIL %s_aborted: got %b, required %b", name, aborted, exp_aborted);
    end
    checks++;
    if (grants_issued !== BUDGET_W'(exp_issued)) begin
      errors++;
      $display("[TB] FAIL %s_issued: got %0d, required %0d", name, grants_issued, exp_issued);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_missing: %0d grants outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic run_and_expect(input int d, input int b, input logic [NUM_REQ-1:0] r,
                                input string name);
    int s;
    @(negedge clk);
    s = cyc + 1;
    push_grants(s, d, 1, b, r);
    div    = DIV_W'(d);
    budget = BUDGET_W'(b);
    req    = r;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(b * (d + 1) + 20, name);
    @(negedge clk);
    check_end(name, 1'b0, b);
    checks++;
    if (grant_idx !== IDX_W'(model_ptr)) begin
      errors++;
      $display("[TB] FAIL %s_last_idx: got %0d, required %0d", name, grant_idx, model_ptr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #23;
    checks++;
    if (grant !== '0 || grant_idx !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || grants_issued !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: grant=%b idx=%0d busy=%b done=%b aborted=%b issued=%0d, required all 0",
               grant, grant_idx, busy, done, aborted, grants_issued);
    end
    @(negedge clk);
    reset = 1'b1;
    model_ptr = NUM_REQ - 1;
  endtask

  task automatic test_back_to_back();
    run_and_expect(0, 4, 4'b1111, "back_to_back");
  endtask

  task automatic test_spaced();
    run_and_expect(3, 3, 4'b0101, "spaced");
  endtask

  task automatic test_budget_zero();
    int s;
    pulse_start(0, 0, 4'b1111, s);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || grant !== '0 || grants_issued !== '0 || aborted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL budget_zero: done=%b busy=%b grant=%b issued=%0d aborted=%b, required 1 0 0000 0 0",
               done, busy, grant, grants_issued, aborted);
    end
  endtask

  task automatic test_abort();
    int s;
    @(negedge clk);
    s = cyc + 1;
    push_grants(s, 1, 1, 3, 4'b0010);
    div = DIV_W'(1); budget = BUDGET_W'(10); req = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycle(s + 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_end("abort", 1'b1, 3);
    checks++;
    if (grant_idx !== IDX_W'(1)) begin
      errors++;
      $display("[TB] FAIL abort_last_idx: got %0d, required 1", grant_idx);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (grants_issued !== BUDGET_W'(3) || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_hold: issued=%0d done=%b, required 3 1", grants_issued, done);
    end
  endtask

  task automatic test_empty_ticks();
    int s;
    pulse_start(1, 2, 4'b0000, s);
`ifdef MARK_TICK_STALL_WATCHDOG_EN
    wait_cycle(s + 8);
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || stalled !== 1'b1 || grants_issued !== '0) begin
      errors++;
      $display("[TB] FAIL stall: done=%b aborted=%b stalled=%b issued=%0d, required 1 1 1 0",
               done, aborted, stalled, grants_issued);
    end
    req = 4'b1000;
    repeat (6) @(negedge clk);
    check_end("stall_hold", 1'b1, 0);
`else
    wait_cycle(s + 10);
    checks++;
    if (busy !== 1'b1 || grants_issued !== '0) begin
      errors++;
      $display("[TB] FAIL empty_ticks_run: busy=%b issued=%0d, required 1 0", busy, grants_issued);
    end
    push_grants(s, 1, 6, 2, 4'b1000);
    req = 4'b1000;
    wait_done(30, "empty_ticks");
    @(negedge clk);
    check_end("empty_ticks", 1'b0, 2);
    checks++;
    if (grant_idx !== IDX_W'(3)) begin
      errors++;
      $display("[TB] FAIL empty_ticks_idx: got %0d, required 3", grant_idx);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    int s;
    @(negedge clk);
    s = cyc + 1;
    push_grants(s, 0, 1, 3, 4'b1111);
    div = '0; budget = BUDGET_W'(20); req = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycle(s + 3);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || grant_idx !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || grants_issued !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: grant=%b idx=%0d busy=%b done=%b aborted=%b issued=%0d, required all 0",
               grant, grant_idx, busy, done, aborted, grants_issued);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run_missing: %0d grants outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_ptr = NUM_REQ - 1;
    run_and_expect(0, 4, 4'b1111, "after_reset");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_spaced();
    test_budget_zero();
    test_abort();
    test_empty_ticks();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mark_tick_scheduler.md
Name: mark_tick_scheduler

Overview:
- Run-time sequencer that shares the single simulation clock between NUM_REQ mark-search engines.
- Divides clk into tick slots of (div+1) cycles. At each tick it issues one one-cycle grant strobe to a requesting engine, chosen round-robin.
- Stops after a programmed budget of grants, on abort, or (optionally) on a stall.
- Sits between the clock/reset generator and the engine array. It replaces a fixed end-of-simulation time with a controlled, countable run.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..16).
- DIV_W, 8, width of the tick divider value.
- BUDGET_W, 32, width of the grant budget and grant counter.
- STALL_TICKS, 16, consecutive empty ticks before a stall abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse: load div/budget and begin a run; accepted in IDLE or DONE only.
- abort  in  1  level; when sampled high in RUN, the run ends.
- div  in  DIV_W  tick period minus 1; sampled at start.
- budget  in  BUDGET_W  number of grants to issue; sampled at start.
- req  in  NUM_REQ  per-engine request, level.
- grant  out  NUM_REQ  one-hot, one-cycle grant strobe.
- grant_idx  out  $clog2(NUM_REQ)  index of the last grant; holds between grants.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- aborted  out  1  high in DONE if the run ended by abort (or stall).
- grants_issued  out  BUDGET_W  grants issued in the current/last run.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all outputs 0; divider count=0; remaining=0.
  - The round-robin pointer is set to the last index, so the first grant goes to the lowest requesting index.
- States: IDLE, RUN, DONE. Encoding is 2-bit and comes from the package.
- IDLE/DONE + start:
  - Load div_q=div, cnt=div, remaining=budget; clear grants_issued and aborted.
  - If budget==0, go to DONE with aborted=0. Otherwise go to RUN.
  - start in RUN is ignored.
- RUN, each cycle:
  - If cnt!=0: cnt decrements.
  - If cnt==0 (tick): cnt reloads div_q.
    - If req!=0: assert grant for exactly that cycle (registered output, visible the cycle after the tick is decided). The winner is the first set req bit strictly after the RR pointer, wrapping NUM_REQ-1 -> 0. Then update the pointer and grant_idx, increment grants_issued, decrement remaining.
    - If req==0: no grant, no decrement; the tick is lost.
- Timing:
  - With div=0, a tick occurs every cycle, giving back-to-back grants.
  - With div=N, grants are separated by N+1 cycles.
  - First tick occurs div+1 cycles after the start cycle.
- Budget exhaustion: on the grant that brings remaining to 0, next state is DONE. The final grant still pulses.
- Abort:
  - abort in RUN takes priority over a same-cycle tick: no grant, state goes to DONE, aborted=1.
  - abort in IDLE/DONE has no effect.
- DONE: done=1 and busy=0 until start. grant_idx and grants_issued hold.
- req changing mid-slot matters only at the tick cycle. A single requester receives every tick.
- Reset mid-run returns to IDLE immediately. No grant is issued in the cycle reset deasserts.
- grants_issued saturates at all-ones (unreachable under a normal budget).

Optional Feature:
- Macro: MARK_TICK_STALL_WATCHDOG_EN.
- Defined:
  - A counter of consecutive RUN ticks with req==0 is cleared on any grant and at start.
  - When it reaches STALL_TICKS, the state goes to DONE with aborted=1.
  - Adds output stalled (1 bit): set with that abort, cleared at start, 0 on reset.
- Undefined: no counter and no stalled port; empty ticks are lost indefinitely.

Decomposition:
- Package mark_sched_pkg:
  - state enum (IDLE=0, RUN=1, DONE=2);
  - index-width helper constant;
  - default STALL_TICKS.
- Sub-module mark_rr_arbiter (NUM_REQ): combinational round-robin pick.
  - Inputs: req and pointer.
  - Outputs: one-hot, index, any.
  - The scheduler owns the pointer register.

Test Plan:
- Reset, then start with div=0, budget=4, req=4'b1111 -> grants 0001,0010,0100,1000 on 4 consecutive cycles; then done=1, grants_issued=4, aborted=0.
- div=3, budget=3, req=4'b0101 -> grants to idx 0,2,0 at 4-cycle spacing; first grant 4 cycles after start.
- budget=0 start -> done=1 the next cycle, no grant, grants_issued=0.
- div=1, budget=10, req=4'b0010, abort raised after 3rd grant, coincident with a tick -> no 4th grant, done=1, aborted=1, grants_issued=3.
- req=0 for 5 ticks, then req=4'b1000 -> no decrement during the empty ticks; grant idx 3; remaining counts correctly. With MARK_TICK_STALL_WATCHDOG_EN and STALL_TICKS=4: done, aborted=1, stalled=1 at the 4th empty tick.
- reset pulsed low mid-RUN -> all outputs 0 asynchronously. After release, start with req=1111 grants idx 0 first.
